// File: rtl/imu_frame_parser.sv
// Assembles 11-byte IMU frames (header, type, 8 payload bytes, checksum) from a UART byte
// stream, verifies the checksum and commits acc/gyro/angle words with per-type update pulses.
module imu_frame_parser #(
  parameter logic [7:0]  HDR_BYTE    = 8'h55,
  parameter int unsigned TIMEOUT_CYC = 250000,
  parameter int unsigned TO_W        = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic [15:0] acc_x,
  output logic [15:0] acc_y,
  output logic [15:0] acc_z,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] gyro_z,
  output logic [15:0] roll,
  output logic [15:0] pitch,
  output logic [15:0] yaw,
  output logic [15:0] temp,
  output logic        acc_upd,
  output logic        gyro_upd,
  output logic        ang_upd,
  output logic        frame_busy,
  output logic [7:0]  cksum_err_cnt,
  output logic [7:0]  timeout_cnt
);

  typedef enum logic [1:0] {StHunt, StType, StPayload, StCksum} state_e;

  localparam logic [TO_W-1:0] TimeoutVal = TO_W'(TIMEOUT_CYC);

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [1:0]        type_q, type_d;
  logic [7:0]        shadow_q [8];
  logic [7:0]        shadow_d [8];
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [15:0]       acc_q [3];
  logic [15:0]       acc_d [3];
  logic [15:0]       gyro_q [3];
  logic [15:0]       gyro_d [3];
  logic [15:0]       ang_q [3];
  logic [15:0]       ang_d [3];
  logic [15:0]       temp_q, temp_d;
  logic              acc_upd_q, acc_upd_d;
  logic              gyro_upd_q, gyro_upd_d;
  logic              ang_upd_q, ang_upd_d;
  logic [7:0]        cksum_err_q, cksum_err_d;
  logic [7:0]        timeout_cnt_q, timeout_cnt_d;
  logic              commit;
  logic [15:0]       word [4];

  // Little-endian words from the completed shadow buffer.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      word[k] = {shadow_q[2*k+1], shadow_q[2*k]};
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sum_d         = sum_q;
    type_d        = type_q;
    shadow_d      = shadow_q;
    to_cnt_d      = to_cnt_q;
    cksum_err_d   = cksum_err_q;
    timeout_cnt_d = timeout_cnt_q;
    commit        = 1'b0;

    if (byte_valid) begin
      // A byte always wins over a timeout firing in the same cycle.
      to_cnt_d = '0;
      unique case (state_q)
        StHunt: begin
          if (byte_data == HDR_BYTE) begin
            state_d = StType;
            sum_d   = HDR_BYTE;
          end
        end
        StType: begin
          if (byte_data == 8'h51 || byte_data == 8'h52 || byte_data == 8'h53) begin
            type_d  = byte_data[1:0];
            sum_d   = sum_q + byte_data;
            idx_d   = 3'd0;
            state_d = StPayload;
          end else if (byte_data == HDR_BYTE) begin
            sum_d = HDR_BYTE;
          end else begin
            state_d = StHunt;
            sum_d   = '0;
          end
        end
        StPayload: begin
          shadow_d[idx_q] = byte_data;
          sum_d           = sum_q + byte_data;
          idx_d           = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = StCksum;
          end
        end
        StCksum: begin
          state_d = StHunt;
          sum_d   = '0;
          if (byte_data == sum_q) begin
            commit = 1'b1;
          end else if (cksum_err_q != 8'hFF) begin
            cksum_err_d = cksum_err_q + 8'd1;
          end
        end
        default: begin
          state_d = StHunt;
        end
      endcase
    end else if (state_q == StHunt) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TimeoutVal) begin
      state_d  = StHunt;
      sum_d    = '0;
      to_cnt_d = '0;
      if (timeout_cnt_q != 8'hFF) begin
        timeout_cnt_d = timeout_cnt_q + 8'd1;
      end
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // Output registers only change on a verified frame.
  always_comb begin
    acc_d      = acc_q;
    gyro_d     = gyro_q;
    ang_d      = ang_q;
    temp_d     = temp_q;
    acc_upd_d  = 1'b0;
    gyro_upd_d = 1'b0;
    ang_upd_d  = 1'b0;
    if (commit) begin
      unique case (type_q)
        2'd1: begin
          acc_d     = '{word[0], word[1], word[2]};
          temp_d    = word[3];
          acc_upd_d = 1'b1;
        end
        2'd2: begin
          gyro_d     = '{word[0], word[1], word[2]};
          temp_d     = word[3];
          gyro_upd_d = 1'b1;
        end
        2'd3: begin
          ang_d     = '{word[0], word[1], word[2]};
          temp_d    = word[3];
          ang_upd_d = 1'b1;
        end
        default: begin
          temp_d = temp_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StHunt;
      idx_q         <= '0;
      sum_q         <= '0;
      type_q        <= '0;
      shadow_q      <= '{default: '0};
      to_cnt_q      <= '0;
      acc_q         <= '{default: '0};
      gyro_q        <= '{default: '0};
      ang_q         <= '{default: '0};
      temp_q        <= '0;
      acc_upd_q     <= 1'b0;
      gyro_upd_q    <= 1'b0;
      ang_upd_q     <= 1'b0;
      cksum_err_q   <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      sum_q         <= sum_d;
      type_q        <= type_d;
      shadow_q      <= shadow_d;
      to_cnt_q      <= to_cnt_d;
      acc_q         <= acc_d;
      gyro_q        <= gyro_d;
      ang_q         <= ang_d;
      temp_q        <= temp_d;
      acc_upd_q     <= acc_upd_d;
      gyro_upd_q    <= gyro_upd_d;
      ang_upd_q     <= ang_upd_d;
      cksum_err_q   <= cksum_err_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign acc_x         = acc_q[0];
  assign acc_y         = acc_q[1];
  assign acc_z         = acc_q[2];
  assign gyro_x        = gyro_q[0];
  assign gyro_y        = gyro_q[1];
  assign gyro_z        = gyro_q[2];
  assign roll          = ang_q[0];
  assign pitch         = ang_q[1];
  assign yaw           = ang_q[2];
  assign temp          = temp_q;
  assign acc_upd       = acc_upd_q;
  assign gyro_upd      = gyro_upd_q;
  assign ang_upd       = ang_upd_q;
  assign frame_busy    = (state_q != StHunt);
  assign cksum_err_cnt = cksum_err_q;
  assign timeout_cnt   = timeout_cnt_q;

endmodule

// File: tb/tb_imu_frame_parser.sv
// Scoreboard bench for imu_frame_parser: directed frames push expected commits into a queue,
// a negedge monitor pops and compares whenever an update strobe appears.
module tb_imu_frame_parser;

  localparam int unsigned T = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [15:0] acc_x, acc_y, acc_z, gyro_x, gyro_y, gyro_z, roll, pitch, yaw, temp;
  logic        acc_upd, gyro_upd, ang_upd, frame_busy;
  logic [7:0]  cksum_err_cnt, timeout_cnt;

  imu_frame_parser #(
    .HDR_BYTE    (8'h55),
    .TIMEOUT_CYC (T),
    .TO_W        (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .byte_data     (byte_data),
    .byte_valid    (byte_valid),
    .acc_x         (acc_x),
    .acc_y         (acc_y),
    .acc_z         (acc_z),
    .gyro_x        (gyro_x),
    .gyro_y        (gyro_y),
    .gyro_z        (gyro_z),
    .roll          (roll),
    .pitch         (pitch),
    .yaw           (yaw),
    .temp          (temp),
    .acc_upd       (acc_upd),
    .gyro_upd      (gyro_upd),
    .ang_upd       (ang_upd),
    .frame_busy    (frame_busy),
    .cksum_err_cnt (cksum_err_cnt),
    .timeout_cnt   (timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  cyc;
    logic [2:0]   upd;   // {acc, gyro, ang}
    logic [159:0] vals;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [15:0] m [10];
  string       fname [10] = '{"acc_x", "acc_y", "acc_z", "gyro_x", "gyro_y", "gyro_z",
                              "roll", "pitch", "yaw", "temp"};
  logic [159:0] act_vals;

  localparam logic [63:0] GyroPay  = 64'h0000_0030_0020_0010;
  localparam logic [63:0] AccPay   = 64'h0000_0000_0000_1234;
  localparam logic [63:0] AngPay   = 64'h0000_0001_8000_FFFF;

  assign act_vals = {acc_x, acc_y, acc_z, gyro_x, gyro_y, gyro_z, roll, pitch, yaw, temp};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] pack_model();
    logic [159:0] v;
    for (int i = 0; i < 10; i++) v[159-16*i -: 16] = m[i];
    return v;
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 10; i++) chk({tag, ".", fname[i]}, 32'(act_vals[159-16*i -: 16]), 32'(m[i]));
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (acc_upd || gyro_upd || ang_upd) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_upd: got %b expected none", {acc_upd, gyro_upd, ang_upd});
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("upd_cycle", cyc, e.cyc);
        chk("upd_kind", 32'({acc_upd, gyro_upd, ang_upd}), 32'(e.upd));
        for (int i = 0; i < 10; i++)
          chk({"commit.", fname[i]}, 32'(act_vals[159-16*i -: 16]), 32'(e.vals[159-16*i -: 16]));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    byte_data  = b;
    byte_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] typ, input logic [63:0] pay, input logic good,
                            input logic [7:0] bad_ck, input int gap_pos, input int gap_len);
    logic [7:0] fr [11];
    logic [7:0] s;
    exp_t       e;
    fr[0] = 8'h55;
    fr[1] = typ;
    for (int i = 0; i < 8; i++) fr[2+i] = pay[8*i +: 8];
    s = 8'h00;
    for (int i = 0; i < 10; i++) s = s + fr[i];
    fr[10] = good ? s : bad_ck;
    for (int i = 0; i < 11; i++) begin
      if (i == 10 && good) begin
        case (typ)
          8'h51:   begin m[0] = pay[15:0]; m[1] = pay[31:16]; m[2] = pay[47:32]; e.upd = 3'b100; end
          8'h52:   begin m[3] = pay[15:0]; m[4] = pay[31:16]; m[5] = pay[47:32]; e.upd = 3'b010; end
          default: begin m[6] = pay[15:0]; m[7] = pay[31:16]; m[8] = pay[47:32]; e.upd = 3'b001; end
        endcase
        m[9]   = pay[63:48];
        e.cyc  = cyc + 1;
        e.vals = pack_model();
        sb.push_back(e);
      end
      send(fr[i]);
      if (i == gap_pos && gap_len > 0) idle(gap_len);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tail [10];
    tail = '{8'h52, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h07};
    for (int i = 0; i < 10; i++) m[i] = 16'h0000;
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_all("reset");
    chk("reset.frame_busy", 32'(frame_busy), 32'd0);
    chk("reset.cksum_err_cnt", 32'(cksum_err_cnt), 32'd0);
    chk("reset.timeout_cnt", 32'(timeout_cnt), 32'd0);

    // Good gyro frame.
    send_frame(8'h52, GyroPay, 1'b1, 8'h00, 99, 0);
    idle(2);
    chk("gyro.gyro_x", 32'(gyro_x), 32'h0010);
    chk("gyro.gyro_y", 32'(gyro_y), 32'h0020);
    chk("gyro.gyro_z", 32'(gyro_z), 32'h0030);
    chk("gyro.acc_x", 32'(acc_x), 32'h0000);

    // Back-to-back acc and angle frames.
    send_frame(8'h51, AccPay, 1'b1, 8'h00, 99, 0);
    send_frame(8'h53, AngPay, 1'b1, 8'h00, 99, 0);
    idle(2);
    chk("acc.acc_x", 32'(acc_x), 32'h1234);
    chk("ang.roll", 32'(roll), 32'hFFFF);
    chk("ang.pitch", 32'(pitch), 32'h8000);
    chk("ang.yaw", 32'(yaw), 32'h0001);
    chk("ang.gyro_x_held", 32'(gyro_x), 32'h0010);

    // Bad checksums leave outputs untouched.
    send_frame(8'h52, GyroPay, 1'b0, 8'h08, 99, 0);
    idle(2);
    chk("bad1.cksum_err_cnt", 32'(cksum_err_cnt), 32'd1);
    check_all("bad1");
    send_frame(8'h52, 64'h0099_0077_0066_0055, 1'b0, 8'h3C, 99, 0);
    idle(2);
    chk("bad2.cksum_err_cnt", 32'(cksum_err_cnt), 32'd2);
    check_all("bad2");

    // A bad checksum byte equal to the header must not start a new frame.
    send_frame(8'h52, GyroPay, 1'b0, 8'h55, 99, 0);
    for (int i = 0; i < 10; i++) send(tail[i]);
    idle(2);
    chk("hdrck.cksum_err_cnt", 32'(cksum_err_cnt), 32'd3);
    chk("hdrck.frame_busy", 32'(frame_busy), 32'd0);

    // Garbage then duplicated header.
    send(8'h00);
    send(8'hAA);
    send(8'h55);
    send_frame(8'h52, GyroPay, 1'b1, 8'h00, 99, 0);
    idle(2);

    // Unknown type then a good acc frame.
    send(8'h55);
    send(8'h54);
    send_frame(8'h51, 64'h0042_0C0B_F00D_BEEF, 1'b1, 8'h00, 99, 0);
    idle(2);
    chk("unk.acc_y", 32'(acc_y), 32'hF00D);
    chk("unk.temp", 32'(temp), 32'h0042);

    // Error counter saturation.
    for (int n = 0; n < 256; n++) send_frame(8'h52, GyroPay, 1'b0, 8'h08, 99, 0);
    idle(2);
    chk("sat.cksum_err_cnt", 32'(cksum_err_cnt), 32'hFF);
    check_all("sat");

    // Inter-byte timeout.
    send(8'h55);
    send(8'h52);
    send(8'h10);
    idle(T);
    chk("to.busy_before", 32'(frame_busy), 32'd1);
    idle(1);
    chk("to.busy_after", 32'(frame_busy), 32'd0);
    chk("to.timeout_cnt", 32'(timeout_cnt), 32'd1);
    send_frame(8'h52, 64'h0004_0300_0200_0100, 1'b1, 8'h00, 99, 0);
    idle(2);
    chk("to.gyro_y", 32'(gyro_y), 32'h0200);

    // Byte arriving exactly when the timeout would fire.
    send_frame(8'h52, GyroPay, 1'b1, 8'h00, 2, T);
    idle(2);
    chk("edge.timeout_cnt", 32'(timeout_cnt), 32'd1);

    // Reset in the middle of a frame.
    send(8'h55);
    send(8'h52);
    send(8'h10);
    send(8'h00);
    byte_valid = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) m[i] = 16'h0000;
    check_all("mrst");
    chk("mrst.frame_busy", 32'(frame_busy), 32'd0);
    chk("mrst.cksum_err_cnt", 32'(cksum_err_cnt), 32'd0);
    chk("mrst.timeout_cnt", 32'(timeout_cnt), 32'd0);
    send_frame(8'h52, GyroPay, 1'b1, 8'h00, 99, 0);
    idle(3);
    chk("mrst.gyro_z", 32'(gyro_z), 32'h0030);
    chk("mrst.acc_x", 32'(acc_x), 32'h0000);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
